rc4_encrypt: RTL
================

# rc4_encrypt

Length-prefixed RC4 encryptor: the transmit-side counterpart of the existing ARC4 decrypt/crack datapath. On a start pulse it initialises and key-schedules an external 256×8 S memory from a 24-bit key, then streams the plaintext memory through the PRGA keystream and writes a ciphertext memory in the same format the decryptor and key cracker consume. It produces encrypted test images on-chip and closes the loop with the decryptor in system tests.

## Interface
Parameters:
- none (memory depth fixed at 256, data width 8)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  start request, sampled only while rdy=1
- rdy  out  1  idle/ready; reset 1
- key  in  24  key; key[23:16] used for i%3==0, key[15:8] for i%3==1, key[7:0] for i%3==2; sampled on the accepted en cycle
- s_addr  out  8  S memory address; reset 0
- s_rddata  in  8  S read data, valid the cycle after s_addr
- s_wrdata  out  8  S write data; reset 0
- s_wren  out  1  S write strobe; reset 0
- pt_addr  out  8  plaintext address; reset 0
- pt_rddata  in  8  plaintext read data, one-cycle latency
- ct_addr  out  8  ciphertext address; reset 0
- ct_wrdata  out  8  ciphertext write data; reset 0
- ct_wren  out  1  ciphertext write strobe; reset 0

## Operation
- Memory format: byte 0 = length L (0..255); bytes 1..L = message. Ciphertext byte 0 = L copied unchanged.
- States: IDLE → INIT → KSA → LEN → PRGA → IDLE.
- IDLE: rdy=1, all strobes 0. en=1 latches key, rdy→0 next cycle, enters INIT. en while rdy=0 is ignored.
- INIT: writes S[n]=n for n=0..255, one write per cycle.
- KSA: for i=0..255: read S[i]; j=(j+S[i]+keybyte[i%3]) mod 256; read S[j]; write S[i]=old S[j]; write S[j]=old S[i]. j starts at 0. All sums 8-bit wrapping. i==j must leave S unchanged (both writes carry the held values, in order).
- LEN: read pt[0], latch L, write ct[0]=L. If L==0, return to IDLE.
- PRGA: i=j=0; for k=1..L: i=i+1; read S[i]; j=j+S[i]; read S[j]; swap as in KSA; read S[(S[i]+S[j]) mod 256] using post-swap values; read pt[k]; write ct[k]=pad^pt[k].
- No more than one S access (read or write) per cycle. The plaintext read may overlap S accesses.
- Never writes pt memory. Writes only ct addresses 0..L.

## Timing
- All reads are issued as an address, with data consumed exactly one cycle later. No combinational path from any rddata to any address or strobe.
- INIT: exactly 256 cycles. KSA: at most 6 cycles per i. PRGA: at most 8 cycles per byte. Total ≤ 2 + 256 + 1536 + 3 + 8L cycles from en to rdy=1.
- rdy rises in the cycle after the final ct write. A new en is accepted in that same rdy=1 cycle.
- s_wren and ct_wren are single-cycle pulses, with address and data valid in the same cycle.
- rst_n low at any time: immediate return to IDLE, outputs at reset values, i/j/k cleared. Partially written memories are not restored.
- Key changes while busy have no effect.

## Configuration
- RC4E_PERF_CNT_EN defined: adds an output port cycles[15:0] (reset 0). It clears on the accepted en, increments every busy cycle, and holds its value while rdy=1, i.e. the total cycle count of the last operation.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

## Test plan
- Reset mid-PRGA (deassert rst_n for 1 cycle during byte 3) → rdy=1 and all strobes 0 immediately; a restarted encrypt gives the correct full result.
- INIT/KSA check: key=24'h000000, L=0 → ct[0]=0, exactly one ct write, rdy returns. S matches the behavioural KSA model for key {0,0,0}.
- Known vector: key=24'h4B6579 ("Key"), pt = 9,"Plaintext" → ct[0]=09, ct[1..9]=BB F3 16 E8 D9 40 AF 0A D3.
- Round trip: key=24'h000018, 64-byte random pt → feed ct to the existing decryptor with the same key → recovered pt is identical, length byte 64.
- Handshake: en held high for 5 cycles, then pulsed again mid-run → exactly one operation. Back-to-back en on the first rdy=1 cycle starts a second run.
- Max length L=255: ct[255] is written, no write to any ct address beyond 255, total cycles within the budget. With RC4E_PERF_CNT_EN defined, cycles equals the measured en→rdy count.

Source files
------------

// File: rtl/rc4_encrypt.sv
// rc4_encrypt: length-prefixed RC4 encryptor driving external S, plaintext and ciphertext memories.
// Define RC4E_PERF_CNT_EN to add the cycles[15:0] port counting busy cycles of the last operation.
module rc4_encrypt (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        rdy,
    input  logic [23:0] key,
    output logic [7:0]  s_addr,
    input  logic [7:0]  s_rddata,
    output logic [7:0]  s_wrdata,
    output logic        s_wren,
    output logic [7:0]  pt_addr,
    input  logic [7:0]  pt_rddata,
    output logic [7:0]  ct_addr,
    output logic [7:0]  ct_wrdata,
    output logic        ct_wren
`ifdef RC4E_PERF_CNT_EN
    ,
    output logic [15:0] cycles
`endif
);
    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_RI, S_DI, S_RJ, S_DJ, S_WI, S_WJ,
        S_RT, S_DT, S_LEN, S_DLEN, S_FIN
    } state_t;

    state_t      r_state;
    logic        r_rdy, r_s_wren, r_ct_wren, r_prga;
    logic [7:0]  r_s_addr, r_s_wrdata, r_pt_addr, r_ct_addr, r_ct_wrdata;
    logic [7:0]  r_i, r_j, r_k, r_len, r_si, r_sj, r_pt;
    logic [1:0]  r_m;
    logic [23:0] r_key;
    logic [7:0]  w_kb, w_jn;

    // KSA mixes in key byte i%3; PRGA shares the same swap sequence with no key term
    assign w_kb = r_prga ? 8'd0 : r_m == 2'd0 ? r_key[23:16] : r_m == 2'd1 ? r_key[15:8] : r_key[7:0];
    assign w_jn = r_j + s_rddata + w_kb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rdy       <= 1'b1;
            r_s_wren    <= 1'b0;
            r_ct_wren   <= 1'b0;
            r_prga      <= 1'b0;
            r_s_addr    <= 8'd0;
            r_s_wrdata  <= 8'd0;
            r_pt_addr   <= 8'd0;
            r_ct_addr   <= 8'd0;
            r_ct_wrdata <= 8'd0;
            r_i         <= 8'd0;
            r_j         <= 8'd0;
            r_k         <= 8'd0;
            r_len       <= 8'd0;
            r_si        <= 8'd0;
            r_sj        <= 8'd0;
            r_pt        <= 8'd0;
            r_m         <= 2'd0;
            r_key       <= 24'd0;
        end else begin
            r_ct_wren <= 1'b0;
            case (r_state)
                S_IDLE: if (en) begin
                    r_key      <= key;
                    r_rdy      <= 1'b0;
                    r_prga     <= 1'b0;
                    r_i        <= 8'd0;
                    r_s_addr   <= 8'd0;
                    r_s_wrdata <= 8'd0;
                    r_s_wren   <= 1'b1;
                    r_state    <= S_INIT;
                end
                S_INIT: if (r_i == 8'd255) begin
                    r_s_wren <= 1'b0;
                    r_s_addr <= 8'd0;
                    r_i      <= 8'd0;
                    r_j      <= 8'd0;
                    r_m      <= 2'd0;
                    r_state  <= S_RI;
                end else begin
                    r_i        <= r_i + 8'd1;
                    r_s_addr   <= r_i + 8'd1;
                    r_s_wrdata <= r_i + 8'd1;
                end
                S_RI: r_state <= S_DI;
                S_DI: begin
                    r_si     <= s_rddata;
                    r_pt     <= pt_rddata;
                    r_j      <= w_jn;
                    r_s_addr <= w_jn;
                    r_state  <= S_RJ;
                end
                S_RJ: r_state <= S_DJ;
                S_DJ: begin
                    r_sj       <= s_rddata;
                    r_s_addr   <= r_i;
                    r_s_wrdata <= s_rddata;
                    r_s_wren   <= 1'b1;
                    r_state    <= S_WI;
                end
                S_WI: begin
                    r_s_addr   <= r_j;
                    r_s_wrdata <= r_si;
                    r_state    <= S_WJ;
                end
                S_WJ: begin
                    r_s_wren <= 1'b0;
                    if (r_prga) begin
                        r_s_addr <= r_si + r_sj;
                        r_state  <= S_RT;
                    end else if (r_i == 8'd255) begin
                        r_pt_addr <= 8'd0;
                        r_state   <= S_LEN;
                    end else begin
                        r_i      <= r_i + 8'd1;
                        r_m      <= r_m == 2'd2 ? 2'd0 : r_m + 2'd1;
                        r_s_addr <= r_i + 8'd1;
                        r_state  <= S_RI;
                    end
                end
                S_RT: r_state <= S_DT;
                S_DT: begin
                    r_ct_addr   <= r_k;
                    r_ct_wrdata <= s_rddata ^ r_pt;
                    r_ct_wren   <= 1'b1;
                    // the ct write overlaps the first S read of the next byte
                    if (r_k == r_len) r_state <= S_FIN;
                    else begin
                        r_k       <= r_k + 8'd1;
                        r_i       <= r_i + 8'd1;
                        r_s_addr  <= r_i + 8'd1;
                        r_pt_addr <= r_k + 8'd1;
                        r_state   <= S_RI;
                    end
                end
                S_LEN: r_state <= S_DLEN;
                S_DLEN: begin
                    r_len       <= pt_rddata;
                    r_ct_addr   <= 8'd0;
                    r_ct_wrdata <= pt_rddata;
                    r_ct_wren   <= 1'b1;
                    if (pt_rddata == 8'd0) r_state <= S_FIN;
                    else begin
                        r_prga    <= 1'b1;
                        r_i       <= 8'd1;
                        r_j       <= 8'd0;
                        r_k       <= 8'd1;
                        r_s_addr  <= 8'd1;
                        r_pt_addr <= 8'd1;
                        r_state   <= S_RI;
                    end
                end
                S_FIN: begin
                    r_rdy   <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rdy       = r_rdy;
    assign s_addr    = r_s_addr;
    assign s_wrdata  = r_s_wrdata;
    assign s_wren    = r_s_wren;
    assign pt_addr   = r_pt_addr;
    assign ct_addr   = r_ct_addr;
    assign ct_wrdata = r_ct_wrdata;
    assign ct_wren   = r_ct_wren;

`ifdef RC4E_PERF_CNT_EN
    logic [15:0] r_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cycles <= 16'd0;
        else if (r_rdy && en) r_cycles <= 16'd0;
        else if (!r_rdy) r_cycles <= r_cycles + 16'd1;
    end

    assign cycles = r_cycles;
`endif
endmodule
